// File: rtl/uart_frame_rx.sv
// UART receiver (8N1) that locks after an idle preamble and assembles key / group-count / payload fields.
// Define UART_FRAME_RX_PARITY_EN for 8E1 framing (even parity checked before the stop bit).
module uart_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 5000,
  parameter int unsigned IDLE_BITS    = 12,
  parameter int unsigned KEY_W        = 128,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_PAY_W    = 384,
  parameter int unsigned PB_W         = 6
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 rx,
  input  logic [PB_W-1:0]      pay_bytes,
  input  logic                 pay_ack,
  output logic [7:0]           byte_data,
  output logic                 byte_valid,
  output logic [KEY_W-1:0]     key,
  output logic                 key_valid,
  output logic [CNT_W-1:0]     grp_cnt,
  output logic                 start,
  output logic [MAX_PAY_W-1:0] pay,
  output logic                 pay_valid,
  output logic                 frm_err,
  output logic                 ovr_err,
  output logic [7:0]           err_cnt,
  output logic                 busy
);

  localparam int unsigned CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW        = $clog2(IDLE_BITS + 1);
  localparam int unsigned KEY_BYTES = KEY_W / 8;
  localparam int unsigned CNT_BYTES = CNT_W / 8;
  localparam int unsigned PAY_BYTES = MAX_PAY_W / 8;
  localparam int unsigned MAX_KC    = (KEY_BYTES > CNT_BYTES) ? KEY_BYTES : CNT_BYTES;
  localparam int unsigned MAX_BYTES = (MAX_KC > PAY_BYTES) ? MAX_KC : PAY_BYTES;
  localparam int unsigned XW        = $clog2(MAX_BYTES + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    B_SYNC,
    B_IDLE,
    B_START,
    B_DATA,
`ifdef UART_FRAME_RX_PARITY_EN
    B_PAR,
`endif
    B_STOP
  } bstate_t;

  typedef enum logic [1:0] {F_KEY, F_CNT, F_PAY, F_HOLD} fstate_t;

  logic                 r_rx_meta, r_rx_sync, r_rx_prev;
  bstate_t              r_bstate, w_bstate_n;
  logic [CW-1:0]        r_baud, w_baud_n;
  logic [IW-1:0]        r_idle, w_idle_n;
  logic [2:0]           r_bit, w_bit_n;
  logic [7:0]           r_shift, w_shift_n;
  logic                 w_good, w_bad;
`ifdef UART_FRAME_RX_PARITY_EN
  logic                 r_par_ok, w_par_ok_n;
`endif
  logic [7:0]           r_byte_data, r_err_cnt;
  logic                 r_byte_valid, r_frm_err, r_busy;

  fstate_t              r_fstate, w_fstate_n;
  logic [XW-1:0]        r_fidx, w_fidx_n;
  logic [XW-1:0]        r_len, w_len_n, w_len_clamp;
  logic [KEY_W-1:0]     r_key, w_key_n;
  logic [CNT_W-1:0]     r_grp_cnt, w_grp_n;
  logic [MAX_PAY_W-1:0] r_pay, w_pay_n;
  logic                 r_pay_valid, w_pay_valid_n;
  logic                 r_key_valid, w_key_valid_n;
  logic                 r_start, w_start_n;
  logic                 r_ovr_err, w_ovr_n;

  // Bit-level receiver: preamble lock, start/data/stop sampling.
  always_comb begin
    w_bstate_n = r_bstate;
    w_baud_n   = r_baud + CW'(1);
    w_idle_n   = r_idle;
    w_bit_n    = r_bit;
    w_shift_n  = r_shift;
    w_good     = 1'b0;
    w_bad      = 1'b0;
`ifdef UART_FRAME_RX_PARITY_EN
    w_par_ok_n = r_par_ok;
`endif
    case (r_bstate)
      B_SYNC: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_n = '0;
          if (!r_rx_sync) begin
            w_idle_n = '0;
          end else if (r_idle == IW'(IDLE_BITS - 1)) begin
            w_idle_n   = '0;
            w_bstate_n = B_IDLE;
          end else begin
            w_idle_n = r_idle + IW'(1);
          end
        end
      end
      B_IDLE: begin
        w_baud_n = '0;
        if (r_rx_prev && !r_rx_sync) w_bstate_n = B_START;
      end
      B_START: begin
        if (r_baud == BAUD_HALF) begin
          w_baud_n   = '0;
          w_bit_n    = '0;
          w_bstate_n = r_rx_sync ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_n  = '0;
          w_shift_n = {r_rx_sync, r_shift[7:1]};
          w_bit_n   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
`ifdef UART_FRAME_RX_PARITY_EN
            w_bstate_n = B_PAR;
`else
            w_bstate_n = B_STOP;
`endif
          end
        end
      end
`ifdef UART_FRAME_RX_PARITY_EN
      B_PAR: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_n   = '0;
          w_par_ok_n = ~(^{r_rx_sync, r_shift});
          w_bstate_n = B_STOP;
        end
      end
`endif
      B_STOP: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_n   = '0;
          w_bstate_n = B_IDLE;
`ifdef UART_FRAME_RX_PARITY_EN
          w_good     = r_rx_sync & r_par_ok;
`else
          w_good     = r_rx_sync;
`endif
          w_bad      = ~w_good;
        end
      end
      default: w_bstate_n = B_SYNC;
    endcase
  end

  // Field assembler: key, group count, then payload rounds with hold/ack.
  always_comb begin
    w_fstate_n    = r_fstate;
    w_fidx_n      = r_fidx;
    w_len_n       = r_len;
    w_key_n       = r_key;
    w_grp_n       = r_grp_cnt;
    w_pay_n       = r_pay;
    w_pay_valid_n = r_pay_valid;
    w_key_valid_n = 1'b0;
    w_start_n     = 1'b0;
    w_ovr_n       = 1'b0;
    w_len_clamp   = ((pay_bytes == '0) || (32'(pay_bytes) > PAY_BYTES)) ? XW'(PAY_BYTES)
                                                                       : XW'(pay_bytes);
    case (r_fstate)
      F_KEY: begin
        if (w_good) begin
          for (int unsigned b = 0; b < KEY_BYTES; b++)
            if (r_fidx == XW'(b)) w_key_n[8*b +: 8] = r_shift;
          if (r_fidx == XW'(KEY_BYTES - 1)) begin
            w_fidx_n      = '0;
            w_key_valid_n = 1'b1;
            w_fstate_n    = F_CNT;
          end else begin
            w_fidx_n = r_fidx + XW'(1);
          end
        end
      end
      F_CNT: begin
        if (w_good) begin
          for (int unsigned b = 0; b < CNT_BYTES; b++)
            if (r_fidx == XW'(b)) w_grp_n[8*b +: 8] = r_shift;
          if (r_fidx == XW'(CNT_BYTES - 1)) begin
            w_fidx_n   = '0;
            w_start_n  = 1'b1;
            w_fstate_n = F_PAY;
            w_pay_n    = '0;
            w_len_n    = w_len_clamp;
          end else begin
            w_fidx_n = r_fidx + XW'(1);
          end
        end
      end
      F_PAY: begin
        if (w_good) begin
          for (int unsigned b = 0; b < PAY_BYTES; b++)
            if (r_fidx == XW'(b)) w_pay_n[8*b +: 8] = r_shift;
          if (r_fidx == r_len - XW'(1)) begin
            w_fidx_n      = '0;
            w_pay_valid_n = 1'b1;
            w_fstate_n    = F_HOLD;
          end else begin
            w_fidx_n = r_fidx + XW'(1);
          end
        end
      end
      F_HOLD: begin
        // A byte completing in the ack cycle is still dropped: the ack wins.
        w_ovr_n = w_good;
        if (pay_ack && r_pay_valid) begin
          w_pay_valid_n = 1'b0;
          w_fidx_n      = '0;
          w_fstate_n    = F_PAY;
          w_pay_n       = '0;
          w_len_n       = w_len_clamp;
        end
      end
      default: w_fstate_n = F_KEY;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_rx_meta    <= 1'b0;
      r_rx_sync    <= 1'b0;
      r_rx_prev    <= 1'b0;
      r_bstate     <= B_SYNC;
      r_baud       <= '0;
      r_idle       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
`ifdef UART_FRAME_RX_PARITY_EN
      r_par_ok     <= 1'b0;
`endif
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_frm_err    <= 1'b0;
      r_err_cnt    <= '0;
      r_busy       <= 1'b0;
      r_fstate     <= F_KEY;
      r_fidx       <= '0;
      r_len        <= '0;
      r_key        <= '0;
      r_grp_cnt    <= '0;
      r_pay        <= '0;
      r_pay_valid  <= 1'b0;
      r_key_valid  <= 1'b0;
      r_start      <= 1'b0;
      r_ovr_err    <= 1'b0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_sync    <= r_rx_meta;
      r_rx_prev    <= r_rx_sync;
      r_bstate     <= w_bstate_n;
      r_baud       <= w_baud_n;
      r_idle       <= w_idle_n;
      r_bit        <= w_bit_n;
      r_shift      <= w_shift_n;
`ifdef UART_FRAME_RX_PARITY_EN
      r_par_ok     <= w_par_ok_n;
`endif
      r_byte_data  <= w_good ? r_shift : r_byte_data;
      r_byte_valid <= w_good;
      r_frm_err    <= w_bad;
      r_err_cnt    <= (w_bad && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1 : r_err_cnt;
      r_busy       <= (w_bstate_n != B_SYNC) && (w_bstate_n != B_IDLE);
      r_fstate     <= w_fstate_n;
      r_fidx       <= w_fidx_n;
      r_len        <= w_len_n;
      r_key        <= w_key_n;
      r_grp_cnt    <= w_grp_n;
      r_pay        <= w_pay_n;
      r_pay_valid  <= w_pay_valid_n;
      r_key_valid  <= w_key_valid_n;
      r_start      <= w_start_n;
      r_ovr_err    <= w_ovr_n;
    end
  end

  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign key        = r_key;
  assign key_valid  = r_key_valid;
  assign grp_cnt    = r_grp_cnt;
  assign start      = r_start;
  assign pay        = r_pay;
  assign pay_valid  = r_pay_valid;
  assign frm_err    = r_frm_err;
  assign ovr_err    = r_ovr_err;
  assign err_cnt    = r_err_cnt;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: a frame-level model queues expected events, a negedge monitor checks them.
module tb_uart_frame_rx;

  localparam int unsigned CPB       = 16;
  localparam int unsigned KEY_W     = 16;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned MAX_PAY_W = 32;
  localparam int unsigned PB_W      = 6;
  localparam int          KEY_BYTES = 2;
  localparam int          CNT_BYTES = 1;
  localparam int          PAY_BYTES = 4;
`ifdef UART_FRAME_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 res = 1'b0;
  logic                 rx = 1'b1;
  logic [PB_W-1:0]      pay_bytes = '0;
  logic                 pay_ack = 1'b0;
  logic [7:0]           byte_data;
  logic                 byte_valid;
  logic [KEY_W-1:0]     key;
  logic                 key_valid;
  logic [CNT_W-1:0]     grp_cnt;
  logic                 start;
  logic [MAX_PAY_W-1:0] pay;
  logic                 pay_valid;
  logic                 frm_err;
  logic                 ovr_err;
  logic [7:0]           err_cnt;
  logic                 busy;

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB), .IDLE_BITS(12), .KEY_W(KEY_W), .CNT_W(CNT_W),
    .MAX_PAY_W(MAX_PAY_W), .PB_W(PB_W)
  ) dut (
    .clk(clk), .res(res), .rx(rx), .pay_bytes(pay_bytes), .pay_ack(pay_ack),
    .byte_data(byte_data), .byte_valid(byte_valid), .key(key), .key_valid(key_valid),
    .grp_cnt(grp_cnt), .start(start), .pay(pay), .pay_valid(pay_valid),
    .frm_err(frm_err), .ovr_err(ovr_err), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Expected-event queues filled by the model, drained by the monitor.
  logic [255:0] exp_byte_q[$];
  logic [255:0] exp_key_q[$];
  logic [255:0] exp_cnt_q[$];
  logic [255:0] exp_pay_q[$];
  logic [255:0] exp_ovr_q[$];
  int           exp_err_q[$];

  // Frame-level model: which field we are filling and the bytes gathered so far.
  int           m_phase;
  logic [7:0]   m_acc[$];
  int           m_len;
  int           m_err;
  logic [255:0] m_pay_cur;

  function automatic int clamp_len(int pb);
    return (pb == 0 || pb > PAY_BYTES) ? PAY_BYTES : pb;
  endfunction

  function automatic logic [255:0] pack_acc();
    logic [255:0] v = '0;
    foreach (m_acc[i]) v = v | (256'(m_acc[i]) << (8 * i));
    return v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_len = 0; m_err = 0; m_pay_cur = '0;
    m_acc.delete();
  endtask

  task automatic model_good(input logic [7:0] b);
    exp_byte_q.push_back(256'(b));
    if (m_phase == 3) begin
      exp_ovr_q.push_back(m_pay_cur);
      return;
    end
    m_acc.push_back(b);
    if (m_phase == 0 && m_acc.size() == KEY_BYTES) begin
      exp_key_q.push_back(pack_acc()); m_acc.delete(); m_phase = 1;
    end else if (m_phase == 1 && m_acc.size() == CNT_BYTES) begin
      exp_cnt_q.push_back(pack_acc()); m_acc.delete(); m_phase = 2;
      m_len = clamp_len(int'(pay_bytes)); m_pay_cur = '0;
    end else if (m_phase == 2 && m_acc.size() == m_len) begin
      m_pay_cur = pack_acc(); exp_pay_q.push_back(m_pay_cur); m_acc.delete(); m_phase = 3;
    end
  endtask

  task automatic model_bad();
    m_err = (m_err < 255) ? m_err + 1 : 255;
    exp_err_q.push_back(m_err);
  endtask

  // Monitor: pops and compares whenever the DUT presents an event.
  int   n_bytes = 0;
  int   n_frm   = 0;
  logic prev_pv = 1'b0;

  always @(negedge clk) begin
    if (!res) begin
      prev_pv = 1'b0;
    end else begin
      if (byte_valid) begin
        n_bytes++;
        chk("byte_expected", 256'(exp_byte_q.size() != 0), 256'(1));
        if (exp_byte_q.size() != 0) chk("byte_data", 256'(byte_data), exp_byte_q.pop_front());
      end
      if (key_valid) begin
        chk("key_expected", 256'(exp_key_q.size() != 0), 256'(1));
        if (exp_key_q.size() != 0) chk("key", 256'(key), exp_key_q.pop_front());
      end
      if (start) begin
        chk("start_expected", 256'(exp_cnt_q.size() != 0), 256'(1));
        if (exp_cnt_q.size() != 0) chk("grp_cnt", 256'(grp_cnt), exp_cnt_q.pop_front());
      end
      if (pay_valid && !prev_pv) begin
        chk("pay_expected", 256'(exp_pay_q.size() != 0), 256'(1));
        if (exp_pay_q.size() != 0) chk("pay", 256'(pay), exp_pay_q.pop_front());
      end
      if (ovr_err) begin
        chk("ovr_expected", 256'(exp_ovr_q.size() != 0), 256'(1));
        if (exp_ovr_q.size() != 0) chk("ovr_pay_kept", 256'(pay), exp_ovr_q.pop_front());
        chk("ovr_pv_kept", 256'(pay_valid), 256'(1));
      end
      if (frm_err) begin
        n_frm++;
        chk("frm_expected", 256'(exp_err_q.size() != 0), 256'(1));
        if (exp_err_q.size() != 0) chk("err_cnt", 256'(err_cnt), 256'(exp_err_q.pop_front()));
      end
      prev_pv = pay_valid;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_bad);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = (^d) ^ par_bad;
      repeat (CPB) @(negedge clk);
    end
    rx = stop_b;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] d);
    model_good(d);
    send_frame(d, 1'b1, 1'b0);
  endtask

  task automatic bad(input logic [7:0] d);
    model_bad();
    send_frame(d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_fields"}, 256'({key, grp_cnt, pay}), 256'(0));
    chk({tag, "_strobes"}, 256'({byte_valid, key_valid, start, pay_valid, frm_err, ovr_err, busy}), 256'(0));
    chk({tag, "_bytes"}, 256'({byte_data, err_cnt}), 256'(0));
  endtask

  task automatic chk_queues(input string tag);
    chk({tag, "_queues_empty"}, 256'(exp_byte_q.size() + exp_key_q.size() + exp_cnt_q.size() +
                                     exp_pay_q.size() + exp_ovr_q.size() + exp_err_q.size()), 256'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    res = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk_queues("reset");
    model_reset();
    res = 1'b1;
  endtask

  task automatic do_ack();
    bit was_hold;
    was_hold = (m_phase == 3);
    @(negedge clk);
    pay_ack = 1'b1;
    if (m_phase == 3) begin
      m_phase = 2; m_acc.delete(); m_len = clamp_len(int'(pay_bytes)); m_pay_cur = '0;
    end
    @(negedge clk);
    pay_ack = 1'b0;
    chk("pv_after_ack", 256'(pay_valid), 256'(0));
    if (was_hold) chk("pay_clr_after_ack", 256'(pay), 256'(0));
  endtask

  int nb_snap, nf_snap;

  initial begin
    model_reset();
    res = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("por");
    res = 1'b1;

    // Preamble one bit short: the byte is ignored.
    idle(11);
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("lock_11_no_byte", 256'(n_bytes), 256'(0));
    idle(12);
    good(8'hA5);
    chk("lock_12_one_byte", 256'(n_bytes), 256'(1));

    // Directed frame with a bad stop bit inside the key field.
    do_reset();
    idle(14);
    pay_bytes = 6'd2;
    good(8'h34);
    bad(8'h3C);
    chk("err_cnt_1", 256'(err_cnt), 256'(1));
    good(8'h12);
    good(8'h02);
    good(8'hEF);
    good(8'hBE);
    chk("key_value", 256'(key), 256'(16'h1234));
    chk("pv_held", 256'(pay_valid), 256'(1));

    // Hold: extra byte dropped, then ack and next round.
    good(8'h55);
    chk("pay_unchanged", 256'(pay), 256'(32'h0000BEEF));
    do_ack();
    good(8'h01);
    good(8'h02);
    chk("pay_round2", 256'(pay), 256'(32'h00000201));

    // Zero length clamps to the full payload width.
    pay_bytes = 6'd0;
    do_ack();
    for (int i = 0; i < PAY_BYTES; i++) good(8'($urandom));

    // Randomised payload rounds with interleaved bad frames and overruns.
    for (int r = 0; r < 5; r++) begin
      pay_bytes = 6'($urandom_range(0, 7));
      do_ack();
      if (r[0]) do_ack();
      for (int i = 0; i < m_len; i++) begin
        if ($urandom_range(0, 3) == 0) bad(8'($urandom));
        good(8'($urandom));
      end
      if ($urandom_range(0, 1) == 1) good(8'($urandom));
    end
    chk("grp_cnt_held", 256'(grp_cnt), 256'(8'h02));

    // Short low glitch: no byte, no error, back to idle.
    nb_snap = n_bytes; nf_snap = n_frm;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(2);
    chk("glitch_no_byte", 256'(n_bytes), 256'(nb_snap));
    chk("glitch_no_err", 256'(n_frm), 256'(nf_snap));
    chk("glitch_not_busy", 256'(busy), 256'(0));

`ifdef UART_FRAME_RX_PARITY_EN
    good(8'h03);
    model_bad();
    send_frame(8'h03, 1'b1, 1'b1);
`endif

    // Error counter saturation.
    for (int i = 0; i < 260; i++) bad(8'($urandom));
    chk("err_cnt_sat", 256'(err_cnt), 256'(255));

    // Reset in the middle of a payload byte, then relock.
    pay_bytes = 6'd3;
    do_ack();
    good(8'h11);
    rx = 1'b0;
    repeat (CPB + CPB / 2 + 3) @(negedge clk);
    #2 res = 1'b0;
    #1 chk_zero("reset_mid");
    chk_queues("reset_mid");
    model_reset();
    repeat (2) @(negedge clk);
    rx = 1'b1;
    res = 1'b1;
    idle(2);
    nb_snap = n_bytes;
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("relock_needed", 256'(n_bytes), 256'(nb_snap));
    idle(14);
    good(8'h77);
    chk("relock_byte", 256'(n_bytes), 256'(nb_snap + 1));
    idle(2);
    chk_queues("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
